// File: rtl/data_bus_arb_pkg.sv
// data_bus_arb_pkg
//   Shared definitions for the two-master data bus arbiter.
//   - arb_state_t : arbiter FSM states (ARB = open round-robin, BURST = M1 locked)
//   - owner_t     : master identifiers (M0 = CPU load/store, M1 = DMA/debug)
//   - BEAT_CNT_W  : width of the locked-burst beat counter
package data_bus_arb_pkg;

  typedef enum logic {
    ARB   = 1'b0,
    BURST = 1'b1
  } arb_state_t;

  typedef enum logic {
    M0 = 1'b0,
    M1 = 1'b1
  } owner_t;

  localparam int BEAT_CNT_W = 4;

endpackage

// File: rtl/arb_resp_slot.sv
// arb_resp_slot
//   Registered response capture for one master. On the edge that ends a
//   granted beat, the bridge's read data is latched and rvalid pulses for
//   one cycle. rdata holds until this master's next granted beat.
// Ports:
//   clk       in   system clock
//   reset     in   synchronous, active-low
//   gnt       in   this master's beat is on the bus this cycle
//   bus_rdata in   read data from the bridge (combinational)
//   rvalid    out  one-cycle response strobe
//   rdata     out  captured read data
module arb_resp_slot (
  input  logic        clk,
  input  logic        reset,
  input  logic        gnt,
  input  logic [31:0] bus_rdata,
  output logic        rvalid,
  output logic [31:0] rdata
);

  always_ff @(posedge clk) begin
    if (!reset) begin
      rvalid <= 1'b0;
      rdata  <= 32'd0;
    end else begin
      rvalid <= gnt;
      if (gnt) begin
        rdata <= bus_rdata;
      end
    end
  end

endmodule

// File: rtl/data_bus_arbiter.sv
// data_bus_arbiter
//   Shares the bridge's single data port between the CPU (M0) and a
//   DMA/debug engine (M1). Round-robin, one beat per cycle. M1 may hold the
//   bus with dma_lock, but once MAX_BURST locked beats have gone by while the
//   CPU is waiting, the CPU is granted the next beat.
// Parameters:
//   MAX_BURST  max consecutive locked M1 beats while M0 requests (1..15)
// Ports:
//   clk, reset                       clock; synchronous active-low reset
//   cpu_req/addr/wdata/byteen        M0 request (held until cpu_gnt)
//   cpu_gnt, cpu_rvalid, cpu_rdata   M0 grant and response
//   dma_req/lock/addr/wdata/byteen   M1 request (held until dma_gnt)
//   dma_gnt, dma_rvalid, dma_rdata   M1 grant and response
//   bus_addr/wdata/byteen            to the bridge's temp_data_* port
//   bus_rdata                        from the bridge (combinational)
module data_bus_arbiter
  import data_bus_arb_pkg::*;
#(
  parameter int MAX_BURST = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        cpu_req,
  input  logic [31:0] cpu_addr,
  input  logic [31:0] cpu_wdata,
  input  logic [3:0]  cpu_byteen,
  output logic        cpu_gnt,
  output logic        cpu_rvalid,
  output logic [31:0] cpu_rdata,
  input  logic        dma_req,
  input  logic        dma_lock,
  input  logic [31:0] dma_addr,
  input  logic [31:0] dma_wdata,
  input  logic [3:0]  dma_byteen,
  output logic        dma_gnt,
  output logic        dma_rvalid,
  output logic [31:0] dma_rdata,
  output logic [31:0] bus_addr,
  output logic [31:0] bus_wdata,
  output logic [3:0]  bus_byteen,
  input  logic [31:0] bus_rdata
);

  localparam logic [BEAT_CNT_W-1:0] MAX_CNT = BEAT_CNT_W'(MAX_BURST);

  arb_state_t             state, state_nxt;
  owner_t                 last, last_nxt;
  logic [BEAT_CNT_W-1:0]  beat_cnt, beat_cnt_nxt;
  logic                   cap_hit;

  always_ff @(posedge clk) begin
    if (!reset) begin
      state    <= ARB;
      last     <= M1;
      beat_cnt <= '0;
    end else begin
      state    <= state_nxt;
      last     <= last_nxt;
      beat_cnt <= beat_cnt_nxt;
    end
  end

  // Grants are suppressed while reset is low so that the beat in flight at
  // the reset edge never reaches the bridge as a committed write.
  always_comb begin
    cpu_gnt      = 1'b0;
    dma_gnt      = 1'b0;
    cap_hit      = 1'b0;
    state_nxt    = state;
    last_nxt     = last;
    beat_cnt_nxt = beat_cnt;

    if (reset) begin
      unique case (state)
        ARB: begin
          if (cpu_req && dma_req) begin
            cpu_gnt = (last == M1);
            dma_gnt = (last == M0);
          end else begin
            cpu_gnt = cpu_req;
            dma_gnt = dma_req;
          end
          if (dma_gnt && dma_lock) begin
            state_nxt    = BURST;
            beat_cnt_nxt = BEAT_CNT_W'(1);
          end else begin
            beat_cnt_nxt = '0;
          end
        end

        BURST: begin
          // >= rather than ==: the counter can run past the cap while the
          // CPU is idle, and a CPU request arriving then must still win.
          cap_hit = cpu_req && (beat_cnt >= MAX_CNT);
          dma_gnt = dma_req && !cap_hit;
          cpu_gnt = cpu_req && !dma_gnt;
          if (dma_gnt && dma_lock) begin
            if (!(&beat_cnt)) begin
              beat_cnt_nxt = beat_cnt + BEAT_CNT_W'(1);
            end
          end else begin
            state_nxt    = ARB;
            beat_cnt_nxt = '0;
          end
        end

        default: begin
          state_nxt    = ARB;
          beat_cnt_nxt = '0;
        end
      endcase

      if (cpu_gnt) begin
        last_nxt = M0;
      end else if (dma_gnt) begin
        last_nxt = M1;
      end
    end
  end

  always_comb begin
    bus_addr   = 32'd0;
    bus_wdata  = 32'd0;
    bus_byteen = 4'd0;
    if (cpu_gnt) begin
      bus_addr   = cpu_addr;
      bus_wdata  = cpu_wdata;
      bus_byteen = cpu_byteen;
    end else if (dma_gnt) begin
      bus_addr   = dma_addr;
      bus_wdata  = dma_wdata;
      bus_byteen = dma_byteen;
    end
  end

  arb_resp_slot u_cpu_slot (
    .clk       (clk),
    .reset     (reset),
    .gnt       (cpu_gnt),
    .bus_rdata (bus_rdata),
    .rvalid    (cpu_rvalid),
    .rdata     (cpu_rdata)
  );

  arb_resp_slot u_dma_slot (
    .clk       (clk),
    .reset     (reset),
    .gnt       (dma_gnt),
    .bus_rdata (bus_rdata),
    .rvalid    (dma_rvalid),
    .rdata     (dma_rdata)
  );

endmodule
